// File: rtl/pd_phy_pkg.sv
// Shared definitions for the BMC transmit path: FSM encoding, preamble length
// and the half-UI divider calculation.
package pd_phy_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_PREAMBLE = 2'd1,
      ST_DATA     = 2'd2,
      ST_TAIL     = 2'd3
   } bmc_state_e;

   localparam int PREAMBLE_BITS = 64;

   function automatic int half_ui(input int system_khz, input int bitrate_khz);
      return system_khz / (2 * bitrate_khz);
   endfunction

endpackage

// File: rtl/bmc_tx_serializer_if.sv
// Word write port of the BMC serializer: valid/ready handshake carrying a
// data word plus its end-of-frame marker.
interface bmc_tx_serializer_if #(
   parameter int data_width = 5
);
   // A word moves when din_valid and din_ready are both high on a rising clock
   // edge; din/din_last must be stable while din_valid is high.
   logic [data_width-1:0] din;
   logic                  din_valid;
   logic                  din_ready;
   logic                  din_last;

   modport master (output din, din_valid, din_last, input din_ready);
   modport slave  (input din, din_valid, din_last, output din_ready);
endinterface

// File: rtl/bmc_tx_fifo.sv
// Small synchronous FIFO with registered full/empty flags and a flush that
// clears it in one cycle; pointers wrap naturally (depth is a power of two).
module bmc_tx_fifo #(
   parameter int width = 6,
   parameter int depth = 4
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             push_i,
   input  logic [width-1:0] wdata_i,
   input  logic             pop_i,
   input  logic             flush_i,
   output logic [width-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);
   localparam int AW = $clog2(depth);
   localparam logic [AW:0] FULL_CNT = depth[AW:0];

   logic [width-1:0] mem_q [depth];
   logic [AW-1:0]    wr_q, rd_q;
   logic [AW:0]      cnt_q, cnt_d;
   logic             full_q, empty_q;
   logic             do_push, do_pop;

   assign do_push = push_i & ~full_q;
   assign do_pop  = pop_i & ~empty_q;

   always_comb begin
      cnt_d = cnt_q;
      if (flush_i) begin
         cnt_d = '0;
      end else begin
         case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_q    <= '0;
         rd_q    <= '0;
         cnt_q   <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         cnt_q   <= cnt_d;
         full_q  <= (cnt_d == FULL_CNT);
         empty_q <= (cnt_d == '0);
         if (flush_i) begin
            wr_q <= '0;
            rd_q <= '0;
         end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push && !flush_i) mem_q[wr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rd_q];
   assign full_o  = full_q;
   assign empty_o = empty_q;
endmodule

// File: rtl/bmc_tx_serializer.sv
// Biphase-mark (BMC) line serializer fed from a word FIFO. Defining
// BMC_PREAMBLE_EN prefixes every frame with 64 alternating 0/1 bits.
module bmc_tx_serializer
   import pd_phy_pkg::*;
#(
   parameter int system_khz  = 200000,
   parameter int bitrate_khz = 300,
   parameter int data_width  = 5,
   parameter int fifo_depth  = 4
) (
   input  logic                clock,
   input  logic                nrst,
   input  logic                enable,
   bmc_tx_serializer_if.slave  din_if,
   output logic                dmc_q,
   output logic                dmc_oe,
   output logic                busy,
   output logic                underrun,
   output bmc_state_e          dbg_state_o
);
   localparam int HALF_UI = half_ui(system_khz, bitrate_khz);
   localparam int HCW     = $clog2(HALF_UI);
`ifdef BMC_PREAMBLE_EN
   localparam int CNT_MAX = (PREAMBLE_BITS > data_width) ? PREAMBLE_BITS : data_width;
`else
   localparam int CNT_MAX = data_width;
`endif
   localparam int BCW     = $clog2(CNT_MAX + 1);

   if (HALF_UI < 2) begin : g_bad_half_ui
      $error("bmc_tx_serializer: HALF_UI must be at least 2");
   end

   // Reset asserts asynchronously but releases two edges after nrst rises.
   logic [1:0] rsync_q;
   logic       rst_n_int;
   always_ff @(posedge clock or negedge nrst) begin
      if (!nrst) rsync_q <= 2'b00;
      else       rsync_q <= {rsync_q[0], 1'b1};
   end
   assign rst_n_int = rsync_q[1];

   logic                  fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
   logic [data_width:0]   fifo_rdata;

   assign din_if.din_ready = rst_n_int & ~fifo_full;
   assign fifo_push        = din_if.din_valid & din_if.din_ready;

   bmc_tx_fifo #(.width(data_width + 1), .depth(fifo_depth)) u_fifo (
      .clk_i   (clock),
      .rst_n_i (rst_n_int),
      .push_i  (fifo_push),
      .wdata_i ({din_if.din_last, din_if.din}),
      .pop_i   (fifo_pop),
      .flush_i (fifo_flush),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   bmc_state_e            state_q, state_d;
   logic [HCW-1:0]        hcnt_q, hcnt_d;
   logic                  phase_q, phase_d;
   logic [BCW-1:0]        bcnt_q, bcnt_d;
   logic [data_width-1:0] sh_q, sh_d;
   logic                  last_q, last_d;
   logic                  line_q, line_d;
   logic                  oe_q, oe_d;
   logic                  urun_q, urun_d;
   logic                  abort_q, abort_d;
   logic                  half_end, cur_bit;

   assign half_end = (hcnt_q == HCW'(HALF_UI - 1));
`ifdef BMC_PREAMBLE_EN
   assign cur_bit  = (state_q == ST_PREAMBLE) ? bcnt_q[0] : sh_q[0];
`else
   assign cur_bit  = sh_q[0];
`endif

   always_ff @(posedge clock or negedge rst_n_int) begin
      if (!rst_n_int) begin
         state_q <= ST_IDLE;
         hcnt_q  <= '0;
         phase_q <= 1'b0;
         bcnt_q  <= '0;
         sh_q    <= '0;
         last_q  <= 1'b0;
         line_q  <= 1'b0;
         oe_q    <= 1'b0;
         urun_q  <= 1'b0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         hcnt_q  <= hcnt_d;
         phase_q <= phase_d;
         bcnt_q  <= bcnt_d;
         sh_q    <= sh_d;
         last_q  <= last_d;
         line_q  <= line_d;
         oe_q    <= oe_d;
         urun_q  <= urun_d;
         abort_q <= abort_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      hcnt_d     = hcnt_q;
      phase_d    = phase_q;
      bcnt_d     = bcnt_q;
      sh_d       = sh_q;
      last_d     = last_q;
      line_d     = line_q;
      oe_d       = oe_q;
      urun_d     = 1'b0;
      abort_d    = abort_q;
      fifo_pop   = 1'b0;
      fifo_flush = 1'b0;

      if (state_q != ST_IDLE) hcnt_d = half_end ? '0 : hcnt_q + 1'b1;

      case (state_q)
         ST_IDLE: begin
            if (enable && !fifo_empty) begin
               line_d  = 1'b1;
               oe_d    = 1'b1;
               hcnt_d  = '0;
               phase_d = 1'b0;
               bcnt_d  = '0;
               abort_d = 1'b0;
`ifdef BMC_PREAMBLE_EN
               state_d = ST_PREAMBLE;
`else
               state_d  = ST_DATA;
               fifo_pop = 1'b1;
               sh_d     = fifo_rdata[data_width-1:0];
               last_d   = fifo_rdata[data_width];
`endif
            end
         end
         ST_PREAMBLE, ST_DATA: begin
            if (!enable) abort_d = 1'b1;
            if (half_end && !phase_q) begin
               phase_d = 1'b1;
               if (cur_bit) line_d = ~line_q;
            end else if (half_end) begin
               // Bit boundary: every outcome below starts with a line toggle.
               phase_d = 1'b0;
               line_d  = ~line_q;
               if (abort_q || !enable) begin
                  state_d    = ST_TAIL;
                  fifo_flush = 1'b1;
               end else if (state_q == ST_DATA && bcnt_q != BCW'(data_width - 1)) begin
                  bcnt_d = bcnt_q + 1'b1;
                  sh_d   = sh_q >> 1;
`ifdef BMC_PREAMBLE_EN
               end else if (state_q == ST_PREAMBLE && bcnt_q != BCW'(PREAMBLE_BITS - 1)) begin
                  bcnt_d = bcnt_q + 1'b1;
`endif
               end else if (state_q == ST_DATA && last_q) begin
                  state_d = ST_TAIL;
               end else if (fifo_empty) begin
                  urun_d  = 1'b1;
                  state_d = ST_TAIL;
               end else begin
                  fifo_pop = 1'b1;
                  sh_d     = fifo_rdata[data_width-1:0];
                  last_d   = fifo_rdata[data_width];
                  bcnt_d   = '0;
                  state_d  = ST_DATA;
               end
            end
         end
         ST_TAIL: begin
            // Leave the line low before releasing the driver.
            if (half_end) begin
               if (!phase_q && line_q) begin
                  line_d  = 1'b0;
                  phase_d = 1'b1;
               end else begin
                  line_d  = 1'b0;
                  phase_d = 1'b0;
                  oe_d    = 1'b0;
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign dmc_q       = line_q;
   assign dmc_oe      = oe_q;
   assign busy        = (state_q != ST_IDLE);
   assign underrun    = urun_q;
   assign dbg_state_o = state_q;
endmodule

// File: tb/tb_bmc_tx_serializer.sv
// Self-checking bench for bmc_tx_serializer at HALF_UI=10: a cycle-level BMC
// model fills an expected queue that is compared sample by sample.
module tb_bmc_tx_serializer;
   import pd_phy_pkg::*;

   localparam int DW = 5;

   logic       clock = 1'b0;
   logic       nrst = 1'b0;
   logic       enable = 1'b0;
   logic       dmc_q, dmc_oe, busy, underrun;
   bmc_state_e dbg_state;

   int n_checks = 0;
   int n_fail   = 0;

   // Expected sample per cycle: {underrun, busy, dmc_oe, dmc_q}
   logic [3:0] exp_q[$];
   logic       bits_q[$];

   bmc_tx_serializer_if #(.data_width(DW)) bus ();

   bmc_tx_serializer #(
      .system_khz  (200000),
      .bitrate_khz (10000),
      .data_width  (DW),
      .fifo_depth  (4)
   ) dut (
      .clock       (clock),
      .nrst        (nrst),
      .enable      (enable),
      .din_if      (bus.slave),
      .dmc_q       (dmc_q),
      .dmc_oe      (dmc_oe),
      .busy        (busy),
      .underrun    (underrun),
      .dbg_state_o (dbg_state)
   );

   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- model ----------------
   task automatic add_word(input logic [DW-1:0] w);
      for (int b = 0; b < DW; b++) bits_q.push_back(w[b]);
   endtask

   task automatic add_preamble(input int nbits);
      for (int i = 0; i < nbits; i++) bits_q.push_back(i[0]);
   endtask

   task automatic add_prefix();
`ifdef BMC_PREAMBLE_EN
      add_preamble(PREAMBLE_BITS);
`endif
   endtask

   task automatic build_frame(input logic urun);
      logic lvl;
      lvl = 1'b0;
      while (bits_q.size() > 0) begin
         logic b;
         b   = bits_q.pop_front();
         lvl = ~lvl;
         for (int c = 0; c < 20; c++) begin
            if (c == 10 && b) lvl = ~lvl;
            exp_q.push_back({1'b0, 1'b1, 1'b1, lvl});
         end
      end
      lvl = ~lvl;
      for (int c = 0; c < 10; c++) exp_q.push_back({urun && (c == 0), 1'b1, 1'b1, lvl});
      if (lvl) for (int c = 0; c < 10; c++) exp_q.push_back(4'b0110);
      for (int c = 0; c < 3; c++) exp_q.push_back(4'b0000);
   endtask

   // ---------------- driver ----------------
   task automatic push_word(input logic [DW-1:0] d, input logic l);
      int n;
      n = 0;
      while (bus.din_ready !== 1'b1 && n < 500) begin
         @(negedge clock);
         n++;
      end
      if (bus.din_ready !== 1'b1) begin
         n_checks++;
         n_fail++;
         $display("FAIL push_timeout: din_ready=%b required 1", bus.din_ready);
      end
      bus.din       = d;
      bus.din_last  = l;
      bus.din_valid = 1'b1;
      @(negedge clock);
      bus.din_valid = 1'b0;
   endtask

   // ---------------- scoreboard ----------------
   task automatic check_frame(input string name, output int waited);
      logic [3:0] got, exp;
      int idx;
      waited = 0;
      idx    = 0;
      while (dmc_oe !== 1'b1 && waited < 3000) begin
         @(negedge clock);
         waited++;
      end
      if (dmc_oe !== 1'b1) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s_start: dmc_oe=%b required 1 within 3000 cycles", name, dmc_oe);
         exp_q.delete();
      end
      while (exp_q.size() > 0) begin
         exp = exp_q.pop_front();
         got = {underrun, busy, dmc_oe, dmc_q};
         n_checks++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL %s_wave: cycle %0d {urun,busy,oe,q}=%b required %b", name, idx, got, exp);
         end
         idx++;
         @(negedge clock);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      nrst          = 1'b0;
      enable        = 1'b0;
      bus.din_valid = 1'b0;
      bus.din       = '0;
      bus.din_last  = 1'b0;
      repeat (3) @(negedge clock);
      n_checks++;
      if ({dmc_q, dmc_oe, busy, underrun} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_outputs: {q,oe,busy,urun}=%b required 0000", {dmc_q, dmc_oe, busy, underrun});
      end
      n_checks++;
      if (bus.din_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ready: din_ready=%b required 0", bus.din_ready);
      end
      n_checks++;
      if (dbg_state !== ST_IDLE) begin
         n_fail++;
         $display("FAIL reset_state: state=%0d required %0d", dbg_state, ST_IDLE);
      end
      nrst = 1'b1;
      @(negedge clock);
      n_checks++;
      if (bus.din_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL release_edge1: din_ready=%b required 0", bus.din_ready);
      end
      @(negedge clock);
      n_checks++;
      if (bus.din_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL release_edge2: din_ready=%b required 1", bus.din_ready);
      end
   endtask

   task automatic test_single_word();
      int waited;
      enable = 1'b1;
      add_prefix();
      add_word(5'b00001);
      build_frame(1'b0);
      push_word(5'b00001, 1'b1);
      n_checks++;
      if (dmc_oe !== 1'b0) begin
         n_fail++;
         $display("FAIL single_pre_start: dmc_oe=%b required 0", dmc_oe);
      end
      check_frame("single", waited);
      n_checks++;
      if (waited != 1) begin
         n_fail++;
         $display("FAIL single_latency: start after %0d cycles required 1", waited);
      end
   endtask

   task automatic test_back_to_back();
      int waited;
      logic [DW-1:0] w[4];
      enable = 1'b0;
      for (int i = 0; i < 4; i++) w[i] = DW'($urandom_range(0, 31));
      add_prefix();
      for (int i = 0; i < 4; i++) add_word(w[i]);
      build_frame(1'b0);
      for (int i = 0; i < 4; i++) push_word(w[i], (i == 3));
      n_checks++;
      if (bus.din_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_full: din_ready=%b required 0", bus.din_ready);
      end
      bus.din       = ~w[0];
      bus.din_last  = 1'b0;
      bus.din_valid = 1'b1;
      @(negedge clock);
      bus.din_valid = 1'b0;
      n_checks++;
      if (bus.din_ready !== 1'b0 || dmc_oe !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_hold: din_ready=%b dmc_oe=%b required 0 0", bus.din_ready, dmc_oe);
      end
      enable = 1'b1;
      @(negedge clock);
      n_checks++;
      if (bus.din_ready !== 1'b1 || dmc_oe !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_start: din_ready=%b dmc_oe=%b required 1 1", bus.din_ready, dmc_oe);
      end
      check_frame("b2b", waited);
   endtask

   task automatic test_underrun();
      int waited;
      logic [DW-1:0] w;
      enable = 1'b1;
      w = DW'($urandom_range(0, 31));
      add_prefix();
      add_word(w);
      build_frame(1'b1);
      push_word(w, 1'b0);
      check_frame("underrun", waited);
   endtask

   task automatic test_random_stream();
      int waited;
      for (int r = 0; r < 3; r++) begin
         int n;
         logic [DW-1:0] w[4];
         n = $urandom_range(1, 4);
         for (int i = 0; i < 4; i++) w[i] = DW'($urandom_range(0, 31));
         enable = 1'b1;
         add_prefix();
         for (int i = 0; i < n; i++) add_word(w[i]);
         build_frame(1'b0);
         fork
            for (int i = 0; i < n; i++) begin
               push_word(w[i], (i == n - 1));
               repeat ($urandom_range(0, 3)) @(negedge clock);
            end
            check_frame("stream", waited);
         join
      end
   endtask

   task automatic test_async_reset();
      int k;
      logic seen_oe;
      enable = 1'b0;
      for (int i = 0; i < 3; i++) push_word(DW'($urandom_range(0, 31)), 1'b0);
      enable = 1'b1;
      k = 0;
      while (dmc_oe !== 1'b1 && k < 3000) begin
         @(negedge clock);
         k++;
      end
      repeat (36) @(negedge clock);
      n_checks++;
      if (dmc_oe !== 1'b1) begin
         n_fail++;
         $display("FAIL arst_in_frame: dmc_oe=%b required 1", dmc_oe);
      end
      #2 nrst = 1'b0;
      #1;
      n_checks++;
      if ({dmc_q, dmc_oe, busy, bus.din_ready} !== 4'b0000) begin
         n_fail++;
         $display("FAIL arst_immediate: {q,oe,busy,ready}=%b required 0000", {dmc_q, dmc_oe, busy, bus.din_ready});
      end
      @(negedge clock);
      nrst = 1'b1;
      repeat (2) @(negedge clock);
      n_checks++;
      if (bus.din_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL arst_release: din_ready=%b required 1", bus.din_ready);
      end
      seen_oe = 1'b0;
      repeat (30) begin
         @(negedge clock);
         if (dmc_oe !== 1'b0) seen_oe = 1'b1;
      end
      n_checks++;
      if (seen_oe !== 1'b0) begin
         n_fail++;
         $display("FAIL arst_fifo_empty: frame started=%b required 0", seen_oe);
      end
   endtask

`ifdef BMC_PREAMBLE_EN
   task automatic test_preamble_abort();
      int waited;
      logic seen_oe;
      enable = 1'b0;
      push_word(DW'($urandom_range(0, 31)), 1'b0);
      push_word(DW'($urandom_range(0, 31)), 1'b1);
      add_preamble(11);
      build_frame(1'b0);
      enable = 1'b1;
      fork
         check_frame("pre_abort", waited);
         begin
            int k;
            k = 0;
            while (dmc_oe !== 1'b1 && k < 3000) begin
               @(negedge clock);
               k++;
            end
            repeat (10 * 20 + 5) @(negedge clock);
            enable = 1'b0;
         end
      join
      enable  = 1'b1;
      seen_oe = 1'b0;
      repeat (30) begin
         @(negedge clock);
         if (dmc_oe !== 1'b0) seen_oe = 1'b1;
      end
      n_checks++;
      if (seen_oe !== 1'b0) begin
         n_fail++;
         $display("FAIL pre_abort_flush: frame started=%b required 0", seen_oe);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single_word();
      test_back_to_back();
      test_underrun();
      test_random_stream();
      test_async_reset();
`ifdef BMC_PREAMBLE_EN
      test_preamble_abort();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
